// File: rtl/dtw_pkg.sv
// Shared constants and helpers for the DTW dependency router: cost-word defaults,
// INF / zero-code encodings, argmin channel codes and MSB-first lane slicing.
package dtw_pkg;

  localparam int DW_DEF = 16;

  localparam logic [1:0] ARG_D0 = 2'd0;
  localparam logic [1:0] ARG_D1 = 2'd1;
  localparam logic [1:0] ARG_D2 = 2'd2;

  // All-ones word of the given width, saturating at 64 bits.
  function automatic logic [63:0] inf_word(input int dw);
    logic [63:0] r;
    if (dw >= 64) begin
      r = {64{1'b1}};
    end else begin
      r = (64'd1 << dw) - 64'd1;
    end
    return r;
  endfunction

  // The all-ones lane code routes a literal zero.
  function automatic logic [63:0] zero_code(input int lw);
    return inf_word(lw);
  endfunction

  // LSB position of a lane in a flattened bus with lane 0 at the MSBs.
  function automatic int lane_lsb(input int lane, input int lanes, input int dw);
    return (lanes - 1 - lane) * dw;
  endfunction

endpackage

// File: rtl/dtw_dep_router_if.sv
// Frame/select input bus and routed-cost output bus of the dependency router.
interface dtw_dep_router_if #(
  parameter int LANES = 6,
  parameter int DW    = 16,
  parameter int HIST  = 2,
  parameter int LW    = $clog2(LANES + 2),
  parameter int AW    = $clog2(HIST + 1)
);
  logic                        i_valid;
  logic [LANES*DW-1:0]         i_d;
  logic [3*LANES*(AW+LW)-1:0]  i_sel;
  logic                        o_valid;
  logic [LANES*DW-1:0]         o_d0;
  logic [LANES*DW-1:0]         o_d1;
  logic [LANES*DW-1:0]         o_d2;
  logic [LANES*DW-1:0]         o_min;
  logic [2*LANES-1:0]          o_arg;

  modport master (
    output i_valid, i_d, i_sel,
    input  o_valid, o_d0, o_d1, o_d2, o_min, o_arg
  );

  modport slave (
    input  i_valid, i_d, i_sel,
    output o_valid, o_d0, o_d1, o_d2, o_min, o_arg
  );
endinterface

// File: rtl/dtw_dep_mux.sv
// Decodes one {age, code} select field into a single cost word taken from the
// current frame, a retained history frame, a literal zero or INF.
module dtw_dep_mux
  import dtw_pkg::*;
#(
  parameter int LANES = 6,
  parameter int DW    = DW_DEF,
  parameter int HIST  = 2,
  parameter int LW    = $clog2(LANES + 2),
  parameter int AW    = $clog2(HIST + 1)
) (
  input  logic [AW+LW-1:0]        sel,
  input  logic [LANES*DW-1:0]     cur,
  input  logic [HIST*LANES*DW-1:0] hist,
  input  logic [AW-1:0]           fill,
  output logic [DW-1:0]           word
);
  localparam int              FRAME   = LANES * DW;
  localparam logic [DW-1:0]   INF_W   = DW'(inf_word(DW));
  localparam logic [LW-1:0]   ZCODE_W = LW'(zero_code(LW));

  logic [AW-1:0]    age_s;
  logic [LW-1:0]    code_s;
  logic [FRAME-1:0] src_s;
  logic             src_ok_s;
  logic             lane_ok_s;
  logic [DW-1:0]    lane_w_s;
  logic             hit_s;

  assign age_s  = sel[AW+LW-1:LW];
  assign code_s = sel[LW-1:0];

  // Pick the source frame by age; ages beyond the filled history stay unresolved.
  always_comb begin
    src_s    = cur;
    src_ok_s = (age_s == '0);
    hit_s    = 1'b0;
    for (int a = 1; a <= HIST; a++) begin
      hit_s    = (age_s == AW'(a)) && (age_s <= fill);
      src_s    = hit_s ? hist[(a-1)*FRAME +: FRAME] : src_s;
      src_ok_s = src_ok_s | hit_s;
    end
  end

  // Lane extraction and final word select; zero code overrides everything.
  always_comb begin
    lane_w_s  = INF_W;
    lane_ok_s = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_ok_s = lane_ok_s | (code_s == LW'(l));
      lane_w_s  = (code_s == LW'(l)) ? src_s[lane_lsb(l, LANES, DW) +: DW] : lane_w_s;
    end
    if (code_s == ZCODE_W) begin
      word = '0;
    end else if (src_ok_s && lane_ok_s) begin
      word = lane_w_s;
    end else begin
      word = INF_W;
    end
  end
endmodule

// File: rtl/dtw_dep_router.sv
// DTW dependency router: frame history, per-lane three-channel routing, and a
// registered min/argmin stage with one cycle of latency.
module dtw_dep_router
  import dtw_pkg::*;
#(
  parameter int LANES = 6,
  parameter int DW    = DW_DEF,
  parameter int HIST  = 2,
  parameter int LW    = $clog2(LANES + 2),
  parameter int AW    = $clog2(HIST + 1)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   ena,
  dtw_dep_router_if.slave        bus
);
  localparam int            FW     = AW + LW;
  localparam int            FRAME  = LANES * DW;
  localparam logic [AW-1:0] HIST_C = AW'(HIST);

  logic [FRAME-1:0]      h_r [HIST];
  logic [AW-1:0]         fill_r;
  logic                  o_valid_r;
  logic [FRAME-1:0]      d0_r, d1_r, d2_r, min_r;
  logic [2*LANES-1:0]    arg_r;

  logic [HIST*FRAME-1:0] hist_s;
  logic [DW-1:0]         route_s [3][LANES];
  logic [DW-1:0]         min_s   [LANES];
  logic [1:0]            arg_s   [LANES];
  logic                  load_s;

  assign load_s = ena & bus.i_valid;

  // Flatten history with h[1] in the lowest frame slot.
  always_comb begin
    hist_s = '0;
    for (int a = 0; a < HIST; a++) begin
      hist_s[a*FRAME +: FRAME] = h_r[a];
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    for (genvar ln = 0; ln < LANES; ln++) begin : g_ln
      dtw_dep_mux #(
        .LANES(LANES), .DW(DW), .HIST(HIST), .LW(LW), .AW(AW)
      ) u_mux (
        .sel  (bus.i_sel[(3*LANES-1-(ch*LANES+ln))*FW +: FW]),
        .cur  (bus.i_d),
        .hist (hist_s),
        .fill (fill_r),
        .word (route_s[ch][ln])
      );
    end
  end

  // Per-lane min3 with strict compares so ties resolve to the lower channel.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      min_s[l] = route_s[0][l];
      arg_s[l] = ARG_D0;
      if (route_s[1][l] < route_s[0][l]) begin
        if (route_s[2][l] < route_s[1][l]) begin
          min_s[l] = route_s[2][l];
          arg_s[l] = ARG_D2;
        end else begin
          min_s[l] = route_s[1][l];
          arg_s[l] = ARG_D1;
        end
      end else begin
        if (route_s[2][l] < route_s[0][l]) begin
          min_s[l] = route_s[2][l];
          arg_s[l] = ARG_D2;
        end else begin
          min_s[l] = route_s[0][l];
          arg_s[l] = ARG_D0;
        end
      end
    end
  end

  // History shift, fill count and output capture share one edge; ena low clears state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int a = 0; a < HIST; a++) h_r[a] <= '0;
      fill_r    <= '0;
      o_valid_r <= 1'b0;
      d0_r      <= '0;
      d1_r      <= '0;
      d2_r      <= '0;
      min_r     <= '0;
      arg_r     <= '0;
    end else if (!ena) begin
      for (int a = 0; a < HIST; a++) h_r[a] <= '0;
      fill_r    <= '0;
      o_valid_r <= 1'b0;
    end else begin
      o_valid_r <= bus.i_valid;
      if (load_s) begin
        h_r[0] <= bus.i_d;
        for (int a = 1; a < HIST; a++) h_r[a] <= h_r[a-1];
        if (fill_r != HIST_C) begin
          fill_r <= fill_r + AW'(1);
        end else begin
          fill_r <= fill_r;
        end
        for (int l = 0; l < LANES; l++) begin
          d0_r[lane_lsb(l, LANES, DW) +: DW]  <= route_s[0][l];
          d1_r[lane_lsb(l, LANES, DW) +: DW]  <= route_s[1][l];
          d2_r[lane_lsb(l, LANES, DW) +: DW]  <= route_s[2][l];
          min_r[lane_lsb(l, LANES, DW) +: DW] <= min_s[l];
          arg_r[lane_lsb(l, LANES, 2) +: 2]   <= arg_s[l];
        end
      end else begin
        fill_r <= fill_r;
      end
    end
  end

  assign bus.o_valid = o_valid_r;
  assign bus.o_d0    = d0_r;
  assign bus.o_d1    = d1_r;
  assign bus.o_d2    = d2_r;
  assign bus.o_min   = min_r;
  assign bus.o_arg   = arg_r;
endmodule

// File: tb/tb_dtw_dep_router.sv
// Bench for dtw_dep_router: directed scenarios plus random traffic, checked
// against a queue-based history model of the routing rules.
module tb_dtw_dep_router;
  localparam int LANES = 6;
  localparam int DW    = 16;
  localparam int HIST  = 2;
  localparam int LW    = 3;
  localparam int AW    = 2;
  localparam int FW    = AW + LW;
  localparam logic [DW-1:0] INF = 16'hFFFF;

  typedef logic [DW-1:0] frame_t [LANES];

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  logic ena  = 1'b0;

  dtw_dep_router_if #(.LANES(LANES), .DW(DW), .HIST(HIST), .LW(LW), .AW(AW)) bus ();

  dtw_dep_router #(.LANES(LANES), .DW(DW), .HIST(HIST), .LW(LW), .AW(AW)) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .ena  (ena),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  frame_t        hq[$];
  frame_t        cur_f;
  int            sa [3][LANES];
  int            sc [3][LANES];
  logic [DW-1:0] e_d [3][LANES];
  logic [DW-1:0] e_min [LANES];
  logic [1:0]    e_arg [LANES];
  logic          e_v;
  int            n_total = 0;
  int            n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_route(input int age, input int code);
    if (code == 7) return '0;
    if (code >= LANES) return INF;
    if (age == 0) return cur_f[code];
    if (age <= hq.size()) return hq[age-1][code];
    return INF;
  endfunction

  function automatic logic [DW-1:0] lane_of(input logic [LANES*DW-1:0] b, input int l);
    return b[(LANES-1-l)*DW +: DW];
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".valid"}, bus.o_valid, e_v);
    for (int l = 0; l < LANES; l++) begin
      check_val($sformatf("%s.d0[%0d]", tag, l), lane_of(bus.o_d0, l), e_d[0][l]);
      check_val($sformatf("%s.d1[%0d]", tag, l), lane_of(bus.o_d1, l), e_d[1][l]);
      check_val($sformatf("%s.d2[%0d]", tag, l), lane_of(bus.o_d2, l), e_d[2][l]);
      check_val($sformatf("%s.min[%0d]", tag, l), lane_of(bus.o_min, l), e_min[l]);
      check_val($sformatf("%s.arg[%0d]", tag, l), bus.o_arg[(LANES-1-l)*2 +: 2], e_arg[l]);
    end
  endtask

  task automatic clear_exp();
    e_v = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < 3; c++) e_d[c][l] = '0;
      e_min[l] = '0;
      e_arg[l] = 2'd0;
    end
  endtask

  task automatic set_sel(input int c, input int age, input int code);
    for (int l = 0; l < LANES; l++) begin
      sa[c][l] = age;
      sc[c][l] = code;
    end
  endtask

  task automatic set_frame(input int base, input int stride);
    for (int l = 0; l < LANES; l++) cur_f[l] = DW'(base + stride * l);
  endtask

  // One cycle: drive, predict from the model, clock, then compare.
  task automatic step(input bit v, input bit e, input string tag);
    logic [DW-1:0] mn;
    bus.i_valid = v;
    ena = e;
    for (int l = 0; l < LANES; l++) begin
      bus.i_d[(LANES-1-l)*DW +: DW] = cur_f[l];
      for (int c = 0; c < 3; c++)
        bus.i_sel[(3*LANES-1-(c*LANES+l))*FW +: FW] = {AW'(sa[c][l]), LW'(sc[c][l])};
    end
    e_v = v && e;
    if (v && e) begin
      for (int l = 0; l < LANES; l++) begin
        for (int c = 0; c < 3; c++) e_d[c][l] = ref_route(sa[c][l], sc[c][l]);
        mn = e_d[0][l];
        for (int c = 1; c < 3; c++) if (e_d[c][l] < mn) mn = e_d[c][l];
        e_min[l] = mn;
        e_arg[l] = 2'd3;
        for (int c = 2; c >= 0; c--) if (e_d[c][l] == mn) e_arg[l] = 2'(c);
      end
      hq.push_front(cur_f);
      if (hq.size() > HIST) void'(hq.pop_back());
    end else if (!e) begin
      hq.delete();
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    nrst = 1'b0;
    #1;
    hq.delete();
    clear_exp();
    check_all(tag);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_d     = '0;
    bus.i_sel   = '0;
    for (int c = 0; c < 3; c++) set_sel(c, 0, 0);
    set_frame(0, 0);
    #3;
    pulse_reset("reset");

    // First frame after reset: age 1 has nothing behind it.
    set_frame(10, 10);
    set_sel(0, 1, 0); set_sel(1, 0, 1); set_sel(2, 0, 2);
    step(1'b1, 1'b1, "first");
    check_val("first.d0_const", lane_of(bus.o_d0, 0), 16'hFFFF);
    check_val("first.min_const", lane_of(bus.o_min, 0), 16'd20);
    check_val("first.arg_const", bus.o_arg[2*LANES-1 -: 2], 2'd1);

    set_frame(1, 1);
    step(1'b1, 1'b1, "frameA");
    set_frame(7, 1);
    set_sel(0, 1, 5); set_sel(1, 0, 0); set_sel(2, 0, 7);
    step(1'b1, 1'b1, "frameB");
    check_val("frameB.d0_const", lane_of(bus.o_d0, 0), 16'd6);
    check_val("frameB.arg_const", bus.o_arg[2*LANES-1 -: 2], 2'd2);

    set_frame(100, 0); step(1'b1, 1'b1, "frameC");
    set_frame(200, 0); step(1'b1, 1'b1, "frameD");
    set_frame(300, 0);
    set_sel(0, 2, 0); set_sel(1, 1, 0); set_sel(2, 3, 0);
    step(1'b1, 1'b1, "frameE");
    check_val("frameE.min_const", lane_of(bus.o_min, 0), 16'd100);
    check_val("frameE.d2_const", lane_of(bus.o_d2, 0), 16'hFFFF);

    set_frame(5, 0);
    for (int c = 0; c < 3; c++) set_sel(c, 0, 0);
    step(1'b1, 1'b1, "tie");
    for (int c = 0; c < 3; c++) set_sel(c, 0, LANES);
    step(1'b1, 1'b1, "allinf");
    check_val("allinf.min_const", lane_of(bus.o_min, 3), 16'hFFFF);

    step(1'b0, 1'b1, "idle");
    set_frame(40, 3);
    step(1'b1, 1'b0, "enalow");
    set_sel(0, 1, 2); set_sel(1, 0, 4); set_sel(2, 1, 0);
    step(1'b1, 1'b1, "afterclr");
    check_val("afterclr.d0_const", lane_of(bus.o_d0, 1), 16'hFFFF);

    set_frame(900, 1);
    step(1'b1, 1'b1, "prerst");
    @(posedge clk);
    #1;
    pulse_reset("midrst");
    set_frame(50, 2);
    step(1'b1, 1'b1, "postrst");
    check_val("postrst.d2_const", lane_of(bus.o_d2, 0), 16'hFFFF);
    step(1'b0, 1'b1, "postrst_idle");

    for (int n = 0; n < 400; n++) begin
      for (int l = 0; l < LANES; l++) begin
        cur_f[l] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
        for (int c = 0; c < 3; c++) begin
          sa[c][l] = $urandom_range(0, 3);
          sc[c][l] = ($urandom_range(0, 9) < 8) ? $urandom_range(0, LANES - 1)
                                                : $urandom_range(LANES, 7);
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        step($urandom_range(0, 9) < 7, $urandom_range(0, 19) != 0, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/dtw_dep_router.md
# dtw_dep_router

Parametrised dependency router for the DTW systolic wavefront. It keeps a short history of accepted distance frames and, per lane, routes three predecessor costs selected by lane index and age. It also computes their registered minimum and argmin. It sits between the systolic array's D output and its D0/D1/D2 inputs, and generalises the fixed two-frame, six-lane selector used by the first generation.

## Interface
Parameters:
- LANES, 6: number of PE lanes per frame.
- DW, 16: cost word width.
- HIST, 2: number of previous frames retained.
- LW, $clog2(LANES+2): lane-code field width.
- AW, $clog2(HIST+1): age field width.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- ena  in  1  enable; low for one cycle or more = synchronous clear.
- i_valid  in  1  i_d holds a new frame this cycle.
- i_d  in  LANES*DW  current cost frame; lane 0 at MSBs.
- i_sel  in  3*LANES*(AW+LW)  select fields, ordered channel-major then lane; channel 0 and lane 0 at MSBs. Each field is {age, code}.
- o_valid  out  1  outputs below are valid.
- o_d0, o_d1, o_d2  out  LANES*DW each  routed costs, lane 0 at MSBs.
- o_min  out  LANES*DW  per-lane minimum of the three routed costs.
- o_arg  out  2*LANES  per-lane argmin channel, 0..2.

## Operation
- History: h[1..HIST], where h[a] is the a-th most recent accepted frame. On a cycle with ena & i_valid: h[1]<=i_d, h[a]<=h[a-1]. Otherwise h holds.
- fill counter, 0..HIST: increments on each accepted frame and saturates at HIST.
- Source of a select field:
  - age 0 → i_d (combinational bypass).
  - age a in 1..HIST with a<=fill → h[a].
  - age a>fill, or a>HIST → INF.
- Code decode:
  - code<LANES → that lane of the chosen source.
  - code = all-ones → 0, regardless of age.
  - any other code → INF.
- INF = all-ones DW (16'hFFFF at default).
- Min/argmin: unsigned compare of the three routed costs. On a tie, the lowest channel index wins (0 before 1 before 2). If all three are INF: o_min=INF, o_arg=0.
- Values are never added or saturated here; outputs carry source words unchanged.
- ena low: h cleared to 0, fill<=0, o_valid<=0. o_d*/o_min/o_arg are held. i_valid is ignored.
- Simultaneous ena low and i_valid: the clear wins and the frame is dropped.

## Timing
- Reset (nrst low, asynchronous): h=0, fill=0, o_valid=0, o_d0/o_d1/o_d2/o_min=0, o_arg=0.
- Latency: 1 cycle. Routing of frame n, using i_d(n) and h before the update, appears on outputs the cycle after i_valid. o_valid is i_valid & ena registered.
- Output registers load only when i_valid & ena. With i_valid low, outputs hold and o_valid=0.
- No backpressure. The upstream array issues at most one frame per cycle and back-to-back frames are supported at full rate.
- History shift and output capture occur on the same edge. Age 1 therefore refers to the previous accepted frame, never the one being written.
- nrst asserted mid-stream: everything returns to reset values immediately. After release, the first frame sees fill=0, so any age>=1 → INF.
- Legal: HIST>=1, LANES>=2. The select field is taken as-is; out-of-range values decode per the rules above. This decode is deliberate and is not an error.

## Structure
- Shared package dtw_pkg holds:
  - DW default and the INF constant function (all-ones of DW).
  - ZERO_CODE (all-ones LW).
  - argmin code localparams ARG_D0=0, ARG_D1=1, ARG_D2=2.
  - helper functions for lane slice indexing, MSB-first.
- Sub-module dtw_dep_mux: one field decode, taking {age, code}, the flattened i_d/h bus and fill, and producing one DW word.
  - Instantiated 3*LANES times in a generate loop.
- The top level holds the history shift register, the fill counter, the min3/argmin tree and the output registers.

## Test plan
- Reset, then first frame i_d lanes=10,20,30,40,50,60; sel ch0 lane0 age1, ch1 lane1 age0, ch2 lane2 age0 → next cycle o_valid=1, o_d0=INF (fill=0), o_d1=20, o_d2=30, o_min=20, o_arg=1.
- Frame A=1..6 then frame B=7..12 back-to-back; ch0 {age1, lane5}, ch1 {age0, lane0}, ch2 code=all-ones → on B's output o_d0=6, o_d1=7, o_d2=0, o_min=0, o_arg=2.
- HIST=2, frames C=100, D=200, E=300 (all lanes); on E, ch0 age2 lane0, ch1 age1 lane0, ch2 age3 → 100, 200, INF; o_min=100, o_arg=0.
- Ties: all three channels route lane value 5 → o_arg=0. Invalid code LANES with age0 on all channels → all INF, o_min=INF, o_arg=0.
- ena low for 1 cycle with i_valid high → o_valid stays 0 and the frame is dropped. The next frame selecting age1 → INF (fill cleared).
- nrst pulse between two frames → outputs 0 immediately; the post-reset frame's age1 select → INF; the o_valid pattern continues correctly.
